// File: rtl/led_pattern_if.sv
// led_pattern_if: control and LED-drive signals of the LED pattern generator.
// The master side (board glue or bench) drives the controls and the slave
// side (led_pattern_gen) returns the LED pattern and the step strobe.
interface led_pattern_if #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8
);
  logic                en;
  logic [1:0]          mode;
  logic                restart;
  logic [PWM_BITS-1:0] brightness;
  logic [NUM_LEDS-1:0] led;
  logic                tick;

  modport master (
    output en, mode, restart, brightness,
    input  led, tick
  );

  modport slave (
    input  en, mode, restart, brightness,
    output led, tick
  );
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator with four selectable
// patterns (rotate, bounce, blink, binary count), enable, synchronous restart
// and a one-cycle step strobe.
// Optional macro LED_PWM_EN adds a free-running PWM counter that gates the
// LEDs with a global brightness duty; without it the LEDs show the raw pattern.
module led_pattern_gen #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 2,
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8
) (
  input logic          clk,
  input logic          rst_n,
  led_pattern_if.slave bus
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int CNT_W    = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("led_pattern_gen: CLK_FREQ / TICK_HZ must be at least 2");
  end
  if (NUM_LEDS < 2) begin : g_bad_num_leds
    $error("led_pattern_gen: NUM_LEDS must be at least 2");
  end
  if (PWM_BITS < 1) begin : g_bad_pwm_bits
    $error("led_pattern_gen: PWM_BITS must be at least 1");
  end

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [CNT_W-1:0]    presc, presc_next;
  logic [NUM_LEDS-1:0] pat, pat_next;
  dir_e                dir, dir_next;
  mode_e               mode_q, mode_next;
  logic                tick_q, tick_next;
  mode_e               mode_in;

  assign mode_in = mode_e'(bus.mode);

  // Starting pattern each mode is (re)entered with.
  function automatic logic [NUM_LEDS-1:0] seed_of(input mode_e m);
    case (m)
      MODE_BLINK: return '1;
      MODE_COUNT: return '0;
      default:    return NUM_LEDS'(1);
    endcase
  endfunction

  // Next-state decode: restart beats a coincident tick; a tick with a new
  // mode only reseeds, otherwise it advances the pattern of the held mode.
  always_comb begin
    presc_next = presc;
    pat_next   = pat;
    dir_next   = dir;
    mode_next  = mode_q;
    tick_next  = 1'b0;
    if (bus.restart) begin
      presc_next = '0;
      mode_next  = mode_in;
      pat_next   = seed_of(mode_in);
      dir_next   = DIR_UP;
    end else if (bus.en) begin
      if (presc == CNT_LAST) begin
        presc_next = '0;
        tick_next  = 1'b1;
        if (mode_in != mode_q) begin
          mode_next = mode_in;
          pat_next  = seed_of(mode_in);
          dir_next  = DIR_UP;
        end else begin
          case (mode_q)
            MODE_ROTATE: pat_next = {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
            MODE_BOUNCE: begin
              if (dir == DIR_UP && pat[NUM_LEDS-1]) begin
                dir_next = DIR_DOWN;
                pat_next = pat >> 1;
              end else if (dir == DIR_DOWN && pat[0]) begin
                dir_next = DIR_UP;
                pat_next = pat << 1;
              end else if (dir == DIR_UP) begin
                pat_next = pat << 1;
              end else begin
                pat_next = pat >> 1;
              end
            end
            MODE_BLINK:  pat_next = ~pat;
            default:     pat_next = pat + NUM_LEDS'(1);
          endcase
        end
      end else begin
        presc_next = presc + CNT_W'(1);
      end
    end
  end

  // Pattern state, prescaler and step strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      pat    <= NUM_LEDS'(1);
      dir    <= DIR_UP;
      mode_q <= MODE_ROTATE;
      tick_q <= 1'b0;
    end else begin
      presc  <= presc_next;
      pat    <= pat_next;
      dir    <= dir_next;
      mode_q <= mode_next;
      tick_q <= tick_next;
    end
  end

  assign bus.tick = tick_q;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] led_q;
  logic                duty_on;

  assign duty_on = (bus.brightness == '1) || (pwm_cnt < bus.brightness);

  // Free-running PWM counter and duty-gated LED register; the LED register
  // follows the next pattern so it still changes on the tick edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led_q   <= pat_next & {NUM_LEDS{duty_on}};
    end
  end

  assign bus.led = led_q;
`else
  logic unused_brightness;

  assign unused_brightness = ^bus.brightness;
  assign bus.led           = pat;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed and randomized checks of led_pattern_gen
// against a step-index reference model. Build with LED_PWM_EN defined to
// also model the brightness gating.
module tb_led_pattern_gen;

  localparam int NL       = 4;
  localparam int PB       = 2;
  localparam int TICK_DIV = 4;

  logic clk;
  logic rst_n;

  led_pattern_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) bus ();

  led_pattern_gen #(
    .CLK_FREQ(8),
    .TICK_HZ (2),
    .NUM_LEDS(NL),
    .PWM_BITS(PB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int tests;
  int failures;

  int m_phase;
  int m_mq;
  int m_k;
  int m_pwm;
  logic [NL-1:0] exp_led;
  logic          exp_tick;

  // Free-running bench clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern after k steps since mode mq was (re)seeded.
  function automatic logic [NL-1:0] patOf(input int mq, input int k);
    int pos;
    case (mq)
      0: return NL'(1 << (k % NL));
      1: begin
        pos = k % (2 * NL - 2);
        if (pos >= NL) pos = 2 * NL - 2 - pos;
        return NL'(1 << pos);
      end
      2: return (k % 2 == 0) ? {NL{1'b1}} : {NL{1'b0}};
      default: return NL'(k % (1 << NL));
    endcase
  endfunction

  task automatic modelReset();
    m_phase  = 0;
    m_mq     = 0;
    m_k      = 0;
    m_pwm    = 0;
    exp_tick = 1'b0;
`ifdef LED_PWM_EN
    exp_led = '0;
`else
    exp_led = NL'(1);
`endif
  endtask

  // One clock edge of the reference model, using the inputs held across it.
  task automatic modelStep();
    logic [NL-1:0] p;
    exp_tick = 1'b0;
    if (bus.restart) begin
      m_phase = 0;
      m_mq    = int'(bus.mode);
      m_k     = 0;
    end else if (bus.en) begin
      if (m_phase == TICK_DIV - 1) begin
        m_phase  = 0;
        exp_tick = 1'b1;
        if (int'(bus.mode) != m_mq) begin
          m_mq = int'(bus.mode);
          m_k  = 0;
        end else begin
          m_k++;
        end
      end else begin
        m_phase++;
      end
    end
    p = patOf(m_mq, m_k);
`ifdef LED_PWM_EN
    if (int'(bus.brightness) == (1 << PB) - 1 || m_pwm < int'(bus.brightness))
      exp_led = p;
    else
      exp_led = '0;
    m_pwm = (m_pwm + 1) % (1 << PB);
`else
    exp_led = p;
`endif
  endtask

  task automatic checkOutput(input string tag);
    tests++;
    assert (bus.led === exp_led) else begin
      failures++;
      $error("[TB] FAIL %s led: got %b, expected %b at %0t", tag, bus.led, exp_led, $time);
    end
    tests++;
    assert (bus.tick === exp_tick) else begin
      failures++;
      $error("[TB] FAIL %s tick: got %b, expected %b at %0t", tag, bus.tick, exp_tick, $time);
    end
  endtask

  // Drive inputs, advance one clock, update the model and compare.
  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic r,
                               input logic [PB-1:0] b, input string tag);
    bus.en         = e;
    bus.mode       = m;
    bus.restart    = r;
    bus.brightness = b;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  // Assert reset away from a clock edge and check the immediate effect.
  task automatic asyncReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    @(posedge clk);
    #1;
    checkOutput(tag);
    rst_n = 1'b1;
  endtask

  task automatic checkAligned(input int guard, input string tag);
    tests++;
    assert (guard < 60) else begin
      failures++;
      $error("[TB] FAIL %s align: loop guard %0d, required below 60", tag, guard);
    end
  endtask

  initial begin
    int g;
    tests          = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.mode       = 2'd0;
    bus.restart    = 1'b0;
    bus.brightness = '1;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset");
    rst_n = 1'b1;

    // Rotate from reset.
    repeat (20) applyStimulus(1'b1, 2'd0, 1'b0, '1, "rotate");

    // Bounce: reseed tick then a full bounce and a bit more.
    repeat (40) applyStimulus(1'b1, 2'd1, 1'b0, '1, "bounce");

    // Blink then count through a full wrap.
    repeat (16) applyStimulus(1'b1, 2'd2, 1'b0, '1, "blink");
    repeat (76) applyStimulus(1'b1, 2'd3, 1'b0, '1, "count");

    // Freeze with the prescaler at 2, then resume.
    g = 0;
    while (m_phase != 2 && g < 60) begin
      applyStimulus(1'b1, 2'd3, 1'b0, '1, "pre_freeze");
      g++;
    end
    checkAligned(g, "freeze");
    repeat (10) applyStimulus(1'b0, 2'd3, 1'b0, '1, "frozen");
    repeat (6) applyStimulus(1'b1, 2'd3, 1'b0, '1, "resume");

    // Restart coinciding with a tick while rotate shows 0100.
    applyStimulus(1'b1, 2'd0, 1'b1, '1, "restart_rot");
    g = 0;
    while (!(m_phase == TICK_DIV - 1 && patOf(m_mq, m_k) == NL'(4)) && g < 60) begin
      applyStimulus(1'b1, 2'd0, 1'b0, '1, "pre_restart");
      g++;
    end
    checkAligned(g, "restart");
    applyStimulus(1'b1, 2'd0, 1'b1, '1, "restart_on_tick");
    repeat (6) applyStimulus(1'b1, 2'd0, 1'b0, '1, "after_restart");

    // Restart while disabled still reseeds.
    applyStimulus(1'b0, 2'd2, 1'b1, '1, "restart_disabled");
    repeat (3) applyStimulus(1'b0, 2'd2, 1'b0, '1, "held_disabled");

    // Async reset in the middle of a bounce.
    repeat (22) applyStimulus(1'b1, 2'd1, 1'b0, '1, "pre_reset_bounce");
    asyncReset("async_reset");
    repeat (8) applyStimulus(1'b1, 2'd0, 1'b0, '1, "after_reset");

    // Brightness corners.
    repeat (12) applyStimulus(1'b1, 2'd0, 1'b0, PB'(1), "bright_1");
    repeat (12) applyStimulus(1'b1, 2'd0, 1'b0, PB'(0), "bright_0");
    repeat (12) applyStimulus(1'b1, 2'd0, 1'b0, '1, "bright_max");

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic          e;
      logic [1:0]    m;
      logic          r;
      logic [PB-1:0] b;
      e = ($urandom_range(0, 7) != 0);
      m = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : bus.mode;
      r = ($urandom_range(0, 29) == 0);
      b = ($urandom_range(0, 15) == 0) ? PB'($urandom_range(0, (1 << PB) - 1)) : bus.brightness;
      applyStimulus(e, m, r, b, "random");
      if (i == 400) asyncReset("random_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
